pa_fetch: RTL and testbench
===========================

PA_FETCH -- requirements
Module: pa_fetch

Interface
REQ-001 The block SHALL have parameter RESET_ADDR, default pa_pkg::PC_RESET_ADDR (32'h1000), the first fetch address after reset.
REQ-002 The block SHALL have parameter EXC_ADDR, default pa_pkg::PC_EXCEPTION_ADDR (32'h8000), the exception redirect address.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port ctrl_i, input, ctrl_if_t: pc_sel = take branch_target_i; stall = hold the presented instruction.
REQ-006 The block SHALL have port branch_target_i, input, 32, the redirect target, sampled when pc_sel=1.
REQ-007 The block SHALL have port exc_i, input, 1, the exception redirect to EXC_ADDR.
REQ-008 The block SHALL have port if_req_o, output, if_req_t, the fetch request to the memory controller.
REQ-009 The block SHALL have port if_resp_i, input, if_resp_t, the fetch response: 32-bit instruction word.
REQ-010 The block SHALL have port instr_o, output, if_stage_t, the fetched instruction to decode.
REQ-011 The block SHALL have port instr_valid_o, output, 1, meaning instr_o/pc_o are valid.
REQ-012 The block SHALL have port pc_o, output, 32, the address of instr_o, or of the faulting target.
REQ-013 The block SHALL have port misalign_o, output, 1, the misaligned-target fault (see Configuration).

Function
REQ-014 The block SHALL implement states REQ, WAIT, DRAIN, HOLD and FAULT, with at most one outstanding request.
REQ-015 In REQ, absent redirect, the block SHALL drive if_req_o.valid=1 and addr=pc for exactly one cycle, then go to WAIT.
REQ-016 In WAIT, on if_resp_i.valid, the block SHALL register data into instr_o, assert instr_valid_o from the next cycle, and go to HOLD.
REQ-017 In HOLD with stall=0, the instruction SHALL be consumed that cycle, and the block SHALL set pc<=pc+4, deassert instr_valid_o and go to REQ.
REQ-018 In HOLD with stall=1, instr_o, pc_o and instr_valid_o SHALL stay unchanged; stall SHALL have no effect in REQ, WAIT and DRAIN.
REQ-019 A redirect SHALL be exc_i=1 (pc<=EXC_ADDR) or pc_sel=1 (pc<=branch_target_i); exc_i SHALL have priority, and a redirect SHALL override stall.
REQ-020 On a redirect in REQ, the block SHALL force if_req_o.valid=0 that cycle, load the new pc and remain in REQ.
REQ-021 On a redirect in HOLD, the block SHALL discard the held instruction, deassert instr_valid_o next cycle and go to REQ.
REQ-022 On a redirect in WAIT without a response, the block SHALL load the new pc and go to DRAIN; a redirect in WAIT with a same-cycle response SHALL drop the response and go to REQ.
REQ-023 In DRAIN, the next if_resp_i.valid SHALL be dropped and the block SHALL go to REQ; a further redirect in DRAIN SHALL update pc and remain in DRAIN.
REQ-024 if_resp_i.valid in REQ, HOLD or FAULT SHALL be ignored.
REQ-025 The pc increment SHALL be modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-026 Minimum fetch-to-fetch spacing SHALL be 3 cycles with a 1-cycle memory response and no stall.

Reset
REQ-027 While rst=1, the block SHALL set state=REQ, pc=RESET_ADDR, instr_o=0, instr_valid_o=0, misalign_o=0 and if_req_o.valid=0.
REQ-028 The first request SHALL be issued, addr=RESET_ADDR, in the first cycle with rst=0.
REQ-029 Reset mid-WAIT or mid-DRAIN SHALL abandon the outstanding request, and the first response after reset SHALL be ignored unless a new request has been issued.

Configuration
REQ-030 With macro PA_FETCH_MISALIGN_EN defined, a redirect target with [1:0]!=0 SHALL issue no request and enter FAULT, with misalign_o=1, pc_o=target and instr_valid_o=0, until the next redirect.
REQ-031 Without PA_FETCH_MISALIGN_EN, target[1:0] SHALL be forced to 2'b00, FAULT SHALL be unreachable and misalign_o SHALL be tied 0.

Verification
REQ-032 Reset release, memory answering after 1 cycle with 32'h0000_0013 -> request addr 32'h1000; instr_valid_o=1 with pc_o=32'h1000 two cycles after the request; next request addr 32'h1004.
REQ-033 stall=1 held for 5 cycles in HOLD -> instr_o/pc_o constant, no request issued; request for pc+4 one cycle after stall drops.
REQ-034 pc_sel=1, target 32'h2000, in WAIT; stale response 32'hDEAD_BEEF 2 cycles later -> response dropped, instr_valid_o stays 0, next request addr 32'h2000.
REQ-035 exc_i=1 and pc_sel=1 (target 32'h3000) in the same cycle -> next request addr 32'h8000.
REQ-036 pc=32'hFFFF_FFFC consumed with stall=0 -> next request addr 32'h0000_0000.
REQ-037 With PA_FETCH_MISALIGN_EN, pc_sel target 32'h2002 -> misalign_o=1, pc_o=32'h2002, no request; without the macro -> request addr 32'h2000.

Source files
------------

// File: rtl/pa_fetch.sv
// pa_fetch: single-outstanding instruction fetch stage.
// REQ issues one request, WAIT collects the response, HOLD presents it to decode.
// DRAIN swallows a response orphaned by a redirect; FAULT parks on a misaligned target.
// Optional feature macro: PA_FETCH_MISALIGN_EN (misaligned redirect targets fault
// instead of being truncated to a word boundary).

package pa_pkg;
    localparam logic [31:0] PC_RESET_ADDR     = 32'h0000_1000;
    localparam logic [31:0] PC_EXCEPTION_ADDR = 32'h0000_8000;

    typedef struct packed {
        logic pc_sel;
        logic stall;
    } ctrl_if_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } if_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } if_resp_t;

    typedef struct packed {
        logic [31:0] instr;
    } if_stage_t;
endpackage

module pa_fetch #(
    parameter logic [31:0] RESET_ADDR = pa_pkg::PC_RESET_ADDR,
    parameter logic [31:0] EXC_ADDR   = pa_pkg::PC_EXCEPTION_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  pa_pkg::ctrl_if_t  ctrl_i,
    input  logic [31:0]       branch_target_i,
    input  logic              exc_i,
    output pa_pkg::if_req_t   if_req_o,
    input  pa_pkg::if_resp_t  if_resp_i,
    output pa_pkg::if_stage_t instr_o,
    output logic              instr_valid_o,
    output logic [31:0]       pc_o,
    output logic              misalign_o
);

    typedef enum logic [2:0] {
        StReq,
        StWait,
        StDrain,
        StHold,
        StFault
    } state_e;

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;

    state_e      w_state_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_instr_next;
    logic        w_valid_next;
    logic        w_req_valid;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_misalign;

    // Exception wins over branch when both redirect in the same cycle.
    assign w_redirect = exc_i | ctrl_i.pc_sel;

`ifdef PA_FETCH_MISALIGN_EN
    assign w_target   = exc_i ? EXC_ADDR : branch_target_i;
    assign w_misalign = (w_target[1:0] != 2'b00);
    assign misalign_o = (r_state == StFault) && !rst;
`else
    // Low bits are dropped so every target is word aligned; FAULT is never entered.
    assign w_target   = (exc_i ? EXC_ADDR : branch_target_i) & 32'hFFFF_FFFC;
    assign w_misalign = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // State register and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StReq;
            r_pc    <= RESET_ADDR;
            r_instr <= 32'h0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
            r_valid <= w_valid_next;
        end
    end

    // Next-state, next-pc and request generation.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        w_valid_next = r_valid;
        w_req_valid  = 1'b0;
        case (r_state)
            StReq: begin
                if (w_redirect) begin
                    w_pc_next    = w_target;
                    w_state_next = w_misalign ? StFault : StReq;
                end else begin
                    w_req_valid  = 1'b1;
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (w_redirect) begin
                    // A same-cycle response is stale; otherwise it is still in flight.
                    w_pc_next = w_target;
                    if (w_misalign) begin
                        w_state_next = StFault;
                    end else begin
                        w_state_next = if_resp_i.valid ? StReq : StDrain;
                    end
                end else if (if_resp_i.valid) begin
                    w_instr_next = if_resp_i.data;
                    w_valid_next = 1'b1;
                    w_state_next = StHold;
                end
            end
            StDrain: begin
                if (w_redirect) begin
                    w_pc_next    = w_target;
                    w_state_next = w_misalign ? StFault : StDrain;
                end else if (if_resp_i.valid) begin
                    w_state_next = StReq;
                end
            end
            StHold: begin
                if (w_redirect) begin
                    w_pc_next    = w_target;
                    w_valid_next = 1'b0;
                    w_state_next = w_misalign ? StFault : StReq;
                end else if (!ctrl_i.stall) begin
                    w_pc_next    = r_pc + 32'd4;
                    w_valid_next = 1'b0;
                    w_state_next = StReq;
                end
            end
            StFault: begin
                if (w_redirect) begin
                    w_pc_next    = w_target;
                    w_state_next = w_misalign ? StFault : StReq;
                end
            end
            default: w_state_next = StReq;
        endcase
    end

    assign if_req_o.valid = w_req_valid & ~rst;
    assign if_req_o.addr  = r_pc;
    assign instr_o.instr  = r_instr;
    assign instr_valid_o  = r_valid;
    assign pc_o           = r_pc;

endmodule

// File: tb/tb_pa_fetch.sv
// Directed, table-driven bench for pa_fetch: one table row per clock cycle.
module tb_pa_fetch;
    import pa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    ctrl_if_t    ctrl;
    logic [31:0] branch_target;
    logic        exc;
    if_req_t     if_req;
    if_resp_t    if_resp;
    if_stage_t   instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pa_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .ctrl_i          (ctrl),
        .branch_target_i (branch_target),
        .exc_i           (exc),
        .if_req_o        (if_req),
        .if_resp_i       (if_resp),
        .instr_o         (instr),
        .instr_valid_o   (instr_valid),
        .pc_o            (pc),
        .misalign_o      (misalign)
    );

    typedef struct {
        logic        rst;
        logic        sel;
        logic        stall;
        logic        exc;
        logic [31:0] tgt;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic s, logic st, logic x, logic [31:0] t, logic rv,
                                logic [31:0] rd, logic er, logic [31:0] ea, logic eiv,
                                logic [31:0] epc, logic [31:0] ei, logic em);
        vec_t v;
        v.rst = r; v.sel = s; v.stall = st; v.exc = x; v.tgt = t; v.rv = rv; v.rd = rd;
        v.e_req = er; v.e_addr = ea; v.e_iv = eiv; v.e_pc = epc; v.e_instr = ei; v.e_mis = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic st, input logic x,
                         input logic [31:0] t, input logic rv, input logic [31:0] rd);
        rst = r; ctrl.pc_sel = s; ctrl.stall = st; exc = x; branch_target = t;
        if_resp.valid = rv; if_resp.data = rd;
    endtask

    initial begin
        int last;
        int nreq;
        logic pending;
        logic [31:0] exp_addr;

        // Columns: rst sel stall exc tgt rv rd | req addr iv pc instr mis
        vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,         0,32'h0,0,32'h1000,32'h0,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         1,32'h1000,0,32'h1000,32'h0,0));
        vq.push_back(mk(0,0,0,0,32'h0,1,32'h13,        0,32'h0,0,32'h1000,32'h0,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         0,32'h0,1,32'h1000,32'h13,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         1,32'h1004,0,32'h1004,32'h13,0));
        vq.push_back(mk(0,0,0,0,32'h0,1,32'h93,        0,32'h0,0,32'h1004,32'h13,0));
        // Five stalled cycles in HOLD, one with a spurious response.
        vq.push_back(mk(0,0,1,0,32'h0,0,32'h0,         0,32'h0,1,32'h1004,32'h93,0));
        vq.push_back(mk(0,0,1,0,32'h0,1,32'hDEADBEEF,  0,32'h0,1,32'h1004,32'h93,0));
        vq.push_back(mk(0,0,1,0,32'h0,0,32'h0,         0,32'h0,1,32'h1004,32'h93,0));
        vq.push_back(mk(0,0,1,0,32'h0,0,32'h0,         0,32'h0,1,32'h1004,32'h93,0));
        vq.push_back(mk(0,0,1,0,32'h0,0,32'h0,         0,32'h0,1,32'h1004,32'h93,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         0,32'h0,1,32'h1004,32'h93,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         1,32'h1008,0,32'h1008,32'h93,0));
        // Branch in WAIT, stale response two cycles later is drained.
        vq.push_back(mk(0,1,0,0,32'h2000,0,32'h0,      0,32'h0,0,32'h1008,32'h93,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         0,32'h0,0,32'h2000,32'h93,0));
        vq.push_back(mk(0,0,0,0,32'h0,1,32'hDEADBEEF,  0,32'h0,0,32'h2000,32'h93,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         1,32'h2000,0,32'h2000,32'h93,0));
        // Stall ignored in WAIT.
        vq.push_back(mk(0,0,1,0,32'h0,1,32'h113,       0,32'h0,0,32'h2000,32'h93,0));
        // Exception and branch together while stalled in HOLD.
        vq.push_back(mk(0,1,1,1,32'h3000,0,32'h0,      0,32'h0,1,32'h2000,32'h113,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         1,32'h8000,0,32'h8000,32'h113,0));
        // Branch in WAIT with same-cycle response: response dropped.
        vq.push_back(mk(0,1,0,0,32'hFFFFFFFC,1,32'h13, 0,32'h0,0,32'h8000,32'h113,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         1,32'hFFFFFFFC,0,32'hFFFFFFFC,32'h113,0));
        vq.push_back(mk(0,0,0,0,32'h0,1,32'h33,        0,32'h0,0,32'hFFFFFFFC,32'h113,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         0,32'h0,1,32'hFFFFFFFC,32'h33,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         1,32'h0,0,32'h0,32'h33,0));
        vq.push_back(mk(0,0,0,0,32'h0,1,32'h73,        0,32'h0,0,32'h0,32'h33,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         0,32'h0,1,32'h0,32'h73,0));
        // Branch in REQ suppresses the request.
        vq.push_back(mk(0,1,0,0,32'h4000,0,32'h0,      0,32'h0,0,32'h4,32'h73,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         1,32'h4000,0,32'h4000,32'h73,0));
        // Second redirect while draining.
        vq.push_back(mk(0,1,0,0,32'h5000,0,32'h0,      0,32'h0,0,32'h4000,32'h73,0));
        vq.push_back(mk(0,1,0,0,32'h6000,0,32'h0,      0,32'h0,0,32'h5000,32'h73,0));
        vq.push_back(mk(0,0,0,0,32'h0,1,32'hDEADBEEF,  0,32'h0,0,32'h6000,32'h73,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         1,32'h6000,0,32'h6000,32'h73,0));
        // Misaligned target.
        vq.push_back(mk(0,1,0,0,32'h2002,1,32'h13,     0,32'h0,0,32'h6000,32'h73,0));
`ifdef PA_FETCH_MISALIGN_EN
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         0,32'h0,0,32'h2002,32'h73,1));
        vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,         0,32'h0,0,32'h2002,32'h73,0));
`else
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         1,32'h2000,0,32'h2000,32'h73,0));
        // Reset while WAIT is outstanding.
        vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,         0,32'h0,0,32'h2000,32'h73,0));
`endif
        // Orphan response right after reset is ignored.
        vq.push_back(mk(0,0,0,0,32'h0,1,32'hDEADBEEF,  1,32'h1000,0,32'h1000,32'h0,0));
        vq.push_back(mk(0,0,0,0,32'h0,1,32'h17,        0,32'h0,0,32'h1000,32'h0,0));
        vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,         0,32'h0,1,32'h1000,32'h17,0));

        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        repeat (2) @(negedge clk);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].sel, vq[i].stall, vq[i].exc, vq[i].tgt, vq[i].rv, vq[i].rd);
            #1;
            chk($sformatf("v%0d req_valid", i), {31'h0, if_req.valid}, {31'h0, vq[i].e_req});
            if (vq[i].e_req) chk($sformatf("v%0d req_addr", i), if_req.addr, vq[i].e_addr);
            chk($sformatf("v%0d instr_valid", i), {31'h0, instr_valid}, {31'h0, vq[i].e_iv});
            chk($sformatf("v%0d pc", i), pc, vq[i].e_pc);
            chk($sformatf("v%0d instr", i), instr.instr, vq[i].e_instr);
            chk($sformatf("v%0d misalign", i), {31'h0, misalign}, {31'h0, vq[i].e_mis});
        end

        // Back-to-back fetching against a 1-cycle memory: requests every 3 cycles.
        last = -1;
        nreq = 0;
        pending = 1'b0;
        exp_addr = 32'h1004;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 32'h0, pending, 32'h13);
            #1;
            pending = if_req.valid;
            if (if_req.valid) begin
                if (last >= 0) chk($sformatf("spacing c%0d", c), c - last, 3);
                chk($sformatf("stream addr c%0d", c), if_req.addr, exp_addr);
                exp_addr += 32'd4;
                last = c;
                nreq++;
            end
        end
        chk("stream request count", nreq, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
